relax_osc_freq_meter: RTL and testbench
=======================================

# relax_osc_freq_meter

Multi-channel digital front end for the relaxation-oscillator macros. It synchronises the comparator outputs of CHANNELS on-die oscillators into the `clk` domain. In frequency mode it counts rising edges over a programmable gate window; in period mode it counts `clk` cycles over a programmable number of oscillator periods. Results are held in per-channel registers with overflow flags and read out through a channel-select mux by the top-level pin logic.

## Interface
Parameters:
- CHANNELS, 4, number of oscillator inputs (1..8)
- CNT_W, 16, width of each result counter and of the timeout counter
- GATE_W, 16, width of `gate_len`

Ports:
- clk  input  1  system clock; all state on its rising edge
- rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high
- osc_in  input  CHANNELS  raw oscillator comparator outputs, asynchronous to `clk`
- mode  input  1  0 = frequency (edge count), 1 = period (cycle count); sampled with `start`
- gate_len  input  GATE_W  frequency mode: window length in `clk` cycles; period mode: number of oscillator periods N; sampled with `start`
- start  input  1  one-cycle request; honoured only in IDLE
- chan_sel  input  $clog2(CHANNELS) (min 1)  selects the result shown on `count_out` and `ovf`
- busy  output  1  high from ARM through LATCH
- done  output  1  one-cycle pulse when new results are valid
- count_out  output  CNT_W  result[chan_sel], combinational mux of result registers
- ovf  output  1  ovf_flag[chan_sel]

## Operation
- Per channel: 2-FF synchroniser (s1, s2), then history flop s3; rise = s2 & ~s3. This chain runs in every state.
- FSM states: IDLE, ARM, MEASURE, LATCH.
  - IDLE -> ARM on `start`=1. Latch `mode`; latch `gate_len` into gate register.
  - If `gate_len`==0, IDLE -> LATCH directly; all results 0, all ovf 0.
  - ARM: clear working counters, per-channel armed/running/done bits and the timeout counter. Always go to MEASURE.
  - MEASURE, frequency mode:
    - Down-count gate register once per cycle; exactly `gate_len` MEASURE cycles.
    - Each rise increments that channel's counter. Counter saturates at 2^CNT_W-1 and sets its ovf bit.
    - -> LATCH in the cycle the gate register reaches 1.
  - MEASURE, period mode:
    - Channel starts running on its first rise and loads an edge counter with N.
    - While running, the channel's counter increments every cycle.
    - Each subsequent rise decrements the edge counter; at 0 the channel is done and its count freezes.
    - A global timeout counter increments every MEASURE cycle.
    - -> LATCH when all channels are done, or when timeout reaches 2^CNT_W-1.
    - On timeout, every unfinished channel records 2^CNT_W-1 with ovf=1.
  - LATCH: copy working counters and ovf bits to the result registers; -> IDLE.
- `start` outside IDLE is ignored (no queuing).
- `mode`/`gate_len` changes outside the start cycle have no effect.
- Result registers keep their values until the next LATCH.

## Timing
- Reset values: FSM=IDLE; all synchroniser, counter, result and ovf registers 0; busy=0; done=0; count_out=0; ovf=0.
- `start` high at edge T: ARM during cycle T+1; MEASURE begins at T+2; `busy` rises after edge T.
- Frequency mode: MEASURE lasts `gate_len` cycles; LATCH occupies one cycle; `done`=1 for exactly the cycle after LATCH, with results already updated; `busy` falls at the same edge.
- Period mode: latency is data-dependent; maximum is 2^CNT_W-1 MEASURE cycles + 3.
- Edge latency: osc_in rise -> rise asserted 3 edges later. Edges arriving in the last 2 cycles before LATCH are lost (accepted ±1 error).
- Valid inputs: osc_in high and low each ≥2 `clk` cycles, i.e. f_osc ≤ f_clk/4.
- `rst` mid-measurement: immediate return to reset values; the previous results are lost; no `done`.
- `chan_sel` ≥ CHANNELS: count_out=0, ovf=0.

## Test plan
- Frequency basic: ch0 square wave with period 8 clk, `gate_len`=800, start -> done 803 cycles after start edge (±1 synchroniser), count_out=100±1, ovf=0, busy high throughout.
- Multi-channel: periods 4/10/20/40 on ch0..3, `gate_len`=400 -> results 100/40/20/10 (±1); sweep `chan_sel` 0..3 and check each.
- Period mode: ch0 period 10 clk, N=16, other channels period 5 -> ch0=160, others=80 (±1); done follows the last channel finishing.
- Timeout/overflow: period mode, ch2 tied low -> done after ~65535 MEASURE cycles, ch2 count 65535 with ovf=1; other channels correct with ovf=0.
- Edge cases: `gate_len`=0 -> done 2 cycles after start, all results 0. `start` pulsed while busy -> ignored, single done. `chan_sel`=5 with CHANNELS=4 -> count_out=0.
- Reset mid-run: assert `rst` 100 cycles into MEASURE -> busy/done/count_out/ovf 0 immediately; a new start afterwards measures correctly.

Source files
------------

// File: rtl/relax_osc_freq_meter.sv
// relax_osc_freq_meter: multi-channel relaxation-oscillator frequency/period meter
module relax_osc_freq_meter #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 16,
  parameter int GATE_W = 16,
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] osc_in,
  input  logic                mode,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic                start,
  input  logic [SEL_W-1:0]    chan_sel,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count_out,
  output logic                ovf
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LATCH} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, done_q, done_d, clr;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CHANNELS-1:0] s1_q, s2_q, s3_q, rise;
  logic [CHANNELS-1:0] run_q, run_d, fin_q, fin_d, ovf_q, ovf_d, rovf_q, rovf_d;
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CNT_W-1:0] res_q [CHANNELS];
  logic [CNT_W-1:0] res_d [CHANNELS];
  logic [GATE_W-1:0] ecnt_q [CHANNELS];
  logic [GATE_W-1:0] ecnt_d [CHANNELS];
  assign rise = s2_q & ~s3_q;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    gate_d = gate_q;
    tmo_d = tmo_q;
    run_d = run_q;
    fin_d = fin_q;
    ovf_d = ovf_q;
    rovf_d = rovf_q;
    cnt_d = cnt_q;
    ecnt_d = ecnt_q;
    res_d = res_q;
    done_d = 1'b0;
    clr = state_q == ARM || (state_q == IDLE && start);
    if (clr) begin
      tmo_d = '0;
      run_d = '0;
      fin_d = '0;
      ovf_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_d[i] = '0;
        ecnt_d[i] = '0;
      end
    end
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        gate_d = gate_len;
        state_d = gate_len == '0 ? LATCH : ARM;
      end
      ARM: state_d = MEASURE;
      MEASURE: if (!mode_q) begin
        gate_d = gate_q - GATE_W'(1);
        for (int i = 0; i < CHANNELS; i++)
          if (rise[i]) begin
            if (&cnt_q[i]) ovf_d[i] = 1'b1;
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        state_d = gate_q == GATE_W'(1) ? LATCH : MEASURE;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
        for (int i = 0; i < CHANNELS; i++) begin
          if (run_q[i]) begin
            if (&cnt_q[i]) ovf_d[i] = 1'b1;
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          if (rise[i] && run_q[i]) begin
            ecnt_d[i] = ecnt_q[i] - GATE_W'(1);
            if (ecnt_q[i] == GATE_W'(1)) begin
              run_d[i] = 1'b0;
              fin_d[i] = 1'b1;
            end
          end else if (rise[i] && !fin_q[i]) begin
            run_d[i] = 1'b1;
            ecnt_d[i] = gate_q;
          end
        end
        if (&fin_d || &tmo_d) begin
          state_d = LATCH;
          for (int i = 0; i < CHANNELS; i++)
            if (!fin_d[i]) begin
              cnt_d[i] = '1;
              ovf_d[i] = 1'b1;
            end
        end
      end
      LATCH: begin
        res_d = cnt_q;
        rovf_d = ovf_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      gate_q <= '0;
      tmo_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      run_q <= '0;
      fin_q <= '0;
      ovf_q <= '0;
      rovf_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
        ecnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      done_q <= done_d;
      gate_q <= gate_d;
      tmo_q <= tmo_d;
      s1_q <= osc_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      run_q <= run_d;
      fin_q <= fin_d;
      ovf_q <= ovf_d;
      rovf_q <= rovf_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      ecnt_q <= ecnt_d;
    end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign count_out = 32'(chan_sel) < CHANNELS ? res_q[chan_sel] : '0;
  assign ovf = 32'(chan_sel) < CHANNELS ? rovf_q[chan_sel] : 1'b0;
endmodule

// File: tb/tb_relax_osc_freq_meter.sv
// tb_relax_osc_freq_meter: vector table, corner sequences and randomized runs against a rise-log model
module tb_relax_osc_freq_meter;
  logic clk = 0, rst = 1, mode = 0, start = 0;
  logic [3:0] osc_in = '0;
  logic [15:0] gate_len = '0;
  logic [1:0] chan_sel = '0;
  logic busy, done, ovf;
  logic [15:0] count_out;
  int cyc = 0, checks = 0, failures = 0;
  int per [4];
  int ph [4];
  int rises [4][$];
  int ecnt [4];
  int eovf [4];
  bit nv;
  typedef struct packed {
    logic m;
    logic [15:0] g;
    logic [3:0][7:0] per;
    logic [3:0][15:0] exp;
    logic [3:0] eov;
    logic [31:0] lat;
  } vec_t;
  vec_t tbl [5];
  relax_osc_freq_meter #(.CHANNELS(4), .CNT_W(16), .GATE_W(16)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .mode(mode), .gate_len(gate_len), .start(start),
    .chan_sel(chan_sel), .busy(busy), .done(done), .count_out(count_out), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      nv = per[i] > 0 ? (((cyc + ph[i]) % per[i]) < per[i] / 2) : 1'b0;
      if (nv && !osc_in[i]) rises[i].push_back(cyc);
      osc_in[i] = nv;
    end
  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask
  function automatic vec_t mk(bit m, int g, int p0, int p1, int p2, int p3,
                              int e0, int e1, int e2, int e3, bit [3:0] eo, int lat);
    vec_t v;
    v.m = m;
    v.g = 16'(g);
    v.per[0] = 8'(p0); v.per[1] = 8'(p1); v.per[2] = 8'(p2); v.per[3] = 8'(p3);
    v.exp[0] = 16'(e0); v.exp[1] = 16'(e1); v.exp[2] = 16'(e2); v.exp[3] = 16'(e3);
    v.eov = eo;
    v.lat = 32'(lat);
    return v;
  endfunction
  function automatic int fmodel(int i, int ts, int g);
    int n = 0;
    for (int j = 0; j < rises[i].size(); j++)
      if (rises[i][j] >= ts - 1 && rises[i][j] <= ts + g - 2) n++;
    return n;
  endfunction
  task automatic set_per(input int p0, input int p1, input int p2, input int p3);
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    for (int i = 0; i < 4; i++) rises[i].delete();
    repeat (10) @(negedge clk);
  endtask
  task automatic run(input bit m, input int g, input int xs, output int ts, output int dc);
    bit bad = 0;
    mode = m;
    gate_len = 16'(g);
    start = 1;
    @(negedge clk);
    ts = cyc;
    start = 0;
    mode = ~m;
    gate_len = ~gate_len;
    dc = -1;
    for (int k = 0; k < 70000; k++) begin
      start = (k == xs);
      if (done) begin
        dc = cyc;
        break;
      end
      if (!busy) bad = 1;
      @(negedge clk);
    end
    start = 0;
    chk("done_seen", int'(dc >= 0), 1, 1);
    chk("busy_until_done", int'(bad), 0, 0);
    chk("busy_low_at_done", int'(busy), 0, 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0, 0);
  endtask
  task automatic check_res(input string tag, input int tol);
    for (int i = 0; i < 4; i++) begin
      chan_sel = 2'(i);
      #1;
      chk($sformatf("%s count ch%0d", tag, i), int'(count_out), ecnt[i] - tol, ecnt[i] + tol);
      chk($sformatf("%s ovf ch%0d", tag, i), int'(ovf), eovf[i], eovf[i]);
    end
    @(negedge clk);
  endtask
  initial begin
    int ts, dc, m, g, maxp, n;
    for (int i = 0; i < 4; i++) begin
      ph[i] = $urandom_range(0, 39);
      per[i] = 0;
    end
    tbl[0] = mk(0, 800, 8, 0, 0, 0, 100, 0, 0, 0, 4'b0000, 802);
    tbl[1] = mk(0, 400, 4, 10, 20, 40, 100, 40, 20, 10, 4'b0000, 402);
    tbl[2] = mk(1, 16, 10, 5, 5, 5, 160, 80, 80, 80, 4'b0000, 0);
    tbl[3] = mk(0, 0, 4, 4, 4, 4, 0, 0, 0, 0, 4'b0000, 1);
    tbl[4] = mk(1, 16, 5, 5, 0, 5, 80, 80, 65535, 80, 4'b0100, 65537);
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0, 0);
    chk("reset done", int'(done), 0, 0);
    for (int i = 0; i < 4; i++) begin
      ecnt[i] = 0;
      eovf[i] = 0;
    end
    rst = 0;
    check_res("reset", 0);
    for (int r = 0; r < 5; r++) begin
      set_per(int'(tbl[r].per[0]), int'(tbl[r].per[1]), int'(tbl[r].per[2]), int'(tbl[r].per[3]));
      run(tbl[r].m, int'(tbl[r].g), -1, ts, dc);
      if (tbl[r].lat != 0) chk($sformatf("row%0d latency", r), dc - ts, int'(tbl[r].lat), int'(tbl[r].lat));
      for (int i = 0; i < 4; i++) begin
        ecnt[i] = int'(tbl[r].exp[i]);
        eovf[i] = int'(tbl[r].eov[i]);
      end
      check_res($sformatf("row%0d", r), tbl[r].g == 0 ? 0 : 1);
    end
    chan_sel = 2;
    set_per(6, 6, 6, 6);
    mode = 0;
    gate_len = 1000;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (100) @(negedge clk);
    rst = 1;
    #1;
    chk("midrun_rst busy", int'(busy), 0, 0);
    chk("midrun_rst done", int'(done), 0, 0);
    chk("midrun_rst count_out", int'(count_out), 0, 0);
    chk("midrun_rst ovf", int'(ovf), 0, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    run(0, 300, -1, ts, dc);
    chk("after_rst latency", dc - ts, 302, 302);
    for (int i = 0; i < 4; i++) begin
      ecnt[i] = fmodel(i, ts, 300);
      eovf[i] = 0;
    end
    check_res("after_rst", 1);
    set_per(4, 8, 12, 16);
    run(0, 200, 50, ts, dc);
    chk("busy_start latency", dc - ts, 202, 202);
    n = 0;
    repeat (40) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    chk("busy_start no_rerun", n, 0, 0);
    for (int i = 0; i < 4; i++) ecnt[i] = fmodel(i, ts, 200);
    check_res("busy_start", 1);
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 1);
      set_per($urandom_range(2, 10) * 2, $urandom_range(2, 10) * 2, $urandom_range(2, 10) * 2, $urandom_range(2, 10) * 2);
      g = m != 0 ? $urandom_range(1, 30) : $urandom_range(1, 600);
      maxp = 0;
      for (int i = 0; i < 4; i++) maxp = per[i] > maxp ? per[i] : maxp;
      run(m[0], g, -1, ts, dc);
      if (m != 0) chk($sformatf("rand%0d period latency", r), dc - ts, g * maxp + 3, g * maxp + maxp + 3);
      else chk($sformatf("rand%0d freq latency", r), dc - ts, g + 2, g + 2);
      for (int i = 0; i < 4; i++) ecnt[i] = m != 0 ? g * per[i] : fmodel(i, ts, g);
      check_res($sformatf("rand%0d", r), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
